// File: rtl/tff_count_ctrl.sv
// Command-driven up/down counter built from a bank of T flip-flops.
// Optional wrap pulse output is enabled by defining TFF_COUNT_CTRL_WRAP_EN.
module tff_count_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_dir,
  input  logic             hold,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             busy,
  output logic             done
`ifdef TFF_COUNT_CTRL_WRAP_EN
  ,
  output logic             wrap
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               step;
  logic               accept;
  logic [WIDTH-1:0]   up_carry;
  logic [WIDTH-1:0]   dn_borrow;

  assign step   = (state_q == RUN) && !hold;
  assign accept = (state_q == IDLE) && cmd_valid;

  // Ripple AND chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
  assign up_carry[0]  = 1'b1;
  assign dn_borrow[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign up_carry[gi]  = up_carry[gi-1] & q_q[gi-1];
      assign dn_borrow[gi] = dn_borrow[gi-1] & ~q_q[gi-1];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = (cmd_len != '0) ? RUN : DONE;
      RUN:  if (step && rem_q == LEN_W'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == RUN) || (state_q == DONE);
    done      = (state_q == DONE);
    t_vec     = '0;
    if (step) t_vec = dir_q ? up_carry : dn_borrow;
  end

  always_comb begin
    q_d   = q_q ^ t_vec;
    rem_d = rem_q;
    dir_d = dir_q;
    if (accept) begin
      rem_d = cmd_len;
      dir_d = cmd_dir;
    end else if (step) begin
      rem_d = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      rem_q <= '0;
      dir_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rem_q <= rem_d;
      dir_q <= dir_d;
    end
  end

  assign Q    = q_q;
  assign Qbar = ~q_q;

`ifdef TFF_COUNT_CTRL_WRAP_EN
  logic wrap_q, wrap_d;

  // A step wraps when it leaves all-ones going up or all-zeros going down.
  always_comb begin
    wrap_d = step && (dir_q ? (&q_q) : ~(|q_q));
  end

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Scoreboard bench for tff_count_ctrl: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_tff_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_len = '0;
  logic       cmd_dir = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] t_vec, Q, Qbar;
  logic       busy, done;
`ifdef TFF_COUNT_CTRL_WRAP_EN
  logic       wrap;
`endif

  tff_count_ctrl #(.WIDTH(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_dir(cmd_dir), .hold(hold), .t_vec(t_vec),
    .Q(Q), .Qbar(Qbar), .busy(busy), .done(done)
`ifdef TFF_COUNT_CTRL_WRAP_EN
    , .wrap(wrap)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         row;
    logic [3:0] q;
    logic [3:0] t;
    logic       b;
    logic       d;
    logic       r;
    logic       w;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   row_n = 0;

  task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("Q", e.row, Q, e.q);
      chk("Qbar", e.row, Qbar, ~e.q);
      chk("t_vec", e.row, t_vec, e.t);
      chk("busy", e.row, {3'b0, busy}, {3'b0, e.b});
      chk("done", e.row, {3'b0, done}, {3'b0, e.d});
      chk("cmd_ready", e.row, {3'b0, cmd_ready}, {3'b0, e.r});
`ifdef TFF_COUNT_CTRL_WRAP_EN
      chk("wrap", e.row, {3'b0, wrap}, {3'b0, e.w});
`endif
      $display("[TB] row %0d Q=%h t_vec=%h busy=%b done=%b ready=%b", e.row, Q, t_vec, busy, done, cmd_ready);
    end
  end

  // Drive this cycle's inputs, queue the outputs expected during this cycle, then clock.
  task automatic cyc(input logic r, input logic v, input logic [7:0] len, input logic d,
                     input logic h, input logic c, input logic [3:0] eq, input logic [3:0] et,
                     input logic eb, input logic ed, input logic er, input logic ew);
    exp_t e;
    rst = r; cmd_valid = v; cmd_len = len; cmd_dir = d; hold = h;
    row_n++;
    if (c) begin
      e.row = row_n; e.q = eq; e.t = et; e.b = eb; e.d = ed; e.r = er; e.w = ew;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    cyc(1,0,0,0,0, 0, 4'h0,4'h0,0,0,0,0);
    cyc(1,0,0,0,0, 1, 4'h0,4'h0,0,0,1,0);
    // Up 5 from 0
    cyc(0,1,5,1,0, 1, 4'h0,4'h0,0,0,1,0);
    cyc(0,0,0,0,0, 1, 4'h0,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h1,4'h3,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h2,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h3,4'h7,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h4,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h5,4'h0,1,1,0,0);
    // Down 7 from 5, wrapping 0 -> 15
    cyc(0,1,7,0,0, 1, 4'h5,4'h0,0,0,1,0);
    cyc(0,0,0,1,0, 1, 4'h5,4'h1,1,0,0,0);
    cyc(0,0,0,1,0, 1, 4'h4,4'h7,1,0,0,0);
    cyc(0,0,0,1,0, 1, 4'h3,4'h1,1,0,0,0);
    cyc(0,0,0,1,0, 1, 4'h2,4'h3,1,0,0,0);
    cyc(0,0,0,1,0, 1, 4'h1,4'h1,1,0,0,0);
    cyc(0,0,0,1,0, 1, 4'h0,4'hF,1,0,0,0);
    cyc(0,0,0,1,0, 1, 4'hF,4'h1,1,0,0,1);
    cyc(0,0,0,0,0, 1, 4'hE,4'h0,1,1,0,0);
    // Zero-length command
    cyc(0,1,0,1,0, 1, 4'hE,4'h0,0,0,1,0);
    cyc(0,0,0,0,0, 1, 4'hE,4'h0,1,1,0,0);
    cyc(0,0,0,0,0, 1, 4'hE,4'h0,0,0,1,0);
    // Reset, then up 4 with hold for 3 cycles after the 2nd step
    cyc(1,0,0,0,0, 1, 4'hE,4'h0,0,0,1,0);
    cyc(0,1,4,1,0, 1, 4'h0,4'h0,0,0,1,0);
    cyc(0,0,0,0,0, 1, 4'h0,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h1,4'h3,1,0,0,0);
    cyc(0,0,0,0,1, 1, 4'h2,4'h0,1,0,0,0);
    cyc(0,0,0,0,1, 1, 4'h2,4'h0,1,0,0,0);
    cyc(0,0,0,0,1, 1, 4'h2,4'h0,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h2,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h3,4'h7,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h4,4'h0,1,1,0,0);
    // Up 10, reset during the 3rd step
    cyc(0,1,10,1,0, 1, 4'h4,4'h0,0,0,1,0);
    cyc(0,0,0,0,0, 1, 4'h4,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h5,4'h3,1,0,0,0);
    cyc(1,1,10,1,0, 1, 4'h6,4'h1,1,0,0,0);
    cyc(0,0,0,0,0, 1, 4'h0,4'h0,0,0,1,0);
    cyc(0,0,0,0,0, 1, 4'h0,4'h0,0,0,1,0);
    // cmd_valid held high with length 2: one accept per 4 cycles
    cyc(0,1,2,1,0, 1, 4'h0,4'h0,0,0,1,0);
    cyc(0,1,2,1,0, 1, 4'h0,4'h1,1,0,0,0);
    cyc(0,1,2,1,0, 1, 4'h1,4'h3,1,0,0,0);
    cyc(0,1,2,1,0, 1, 4'h2,4'h0,1,1,0,0);
    cyc(0,1,2,1,0, 1, 4'h2,4'h0,0,0,1,0);
    cyc(0,1,2,1,0, 1, 4'h2,4'h1,1,0,0,0);
    cyc(0,1,2,1,0, 1, 4'h3,4'h7,1,0,0,0);
    cyc(0,1,2,1,0, 1, 4'h4,4'h0,1,1,0,0);
    cyc(0,0,0,0,0, 1, 4'h4,4'h0,0,0,1,0);
    cyc(0,0,0,0,0, 1, 4'h4,4'h0,0,0,1,0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
